// File: rtl/alu_wb_buffer_pkg.sv
// Shared ISA constants for the writeback path: default data width,
// register-index width and the hard-wired zero register.
package alu_wb_buffer_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  function automatic logic is_zero_reg(input reg_idx_t rd);
    return rd == ZERO_REG;
  endfunction

endpackage

// File: rtl/alu_wb_buffer_if.sv
// Handshake bundle between the ALU, the writeback buffer and the register file.
// The slave modport is the buffer's view; master is the surrounding pipeline.
interface alu_wb_buffer_if #(
  parameter int WIDTH = alu_wb_buffer_pkg::XLEN,
  parameter int DEPTH = 2
) ();
  import alu_wb_buffer_pkg::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data;
  reg_idx_t                 in_rd;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  reg_idx_t                 out_rd;
  logic [$clog2(DEPTH):0]   count;

  modport slave (
    input  in_valid, in_data, in_rd, flush, out_ready,
    output in_ready, out_valid, out_data, out_rd, count
  );

  modport master (
    output in_valid, in_data, in_rd, flush, out_ready,
    input  in_ready, out_valid, out_data, out_rd, count
  );

endinterface

// File: rtl/alu_wb_buffer_ram.sv
// Entry storage for the writeback buffer: DEPTH registers of {rd, data},
// one synchronous write port and one asynchronous read port.
module wb_buf_ram
  import alu_wb_buffer_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          we_i,
  input  logic [$clog2(DEPTH)-1:0]      waddr_i,
  input  logic [WIDTH+REG_IDX_W-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0]      raddr_i,
  output logic [WIDTH+REG_IDX_W-1:0]    rdata_o
);

  localparam int EW = WIDTH + REG_IDX_W;

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_wb_buffer.sv
// Small in-order buffer between the ALU and register-file writeback.
// Results to x0 are accepted and dropped; flush discards everything queued.
module alu_wb_buffer
  import alu_wb_buffer_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_wb_buffer_if.slave    bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = WIDTH + REG_IDX_W;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;
  reg_idx_t         hold_rd_q, hold_rd_d;

  logic             in_ready_w;
  logic             out_valid_w;
  logic             push;
  logic             pop;
  logic [EW-1:0]    wr_entry;
  logic [EW-1:0]    rd_entry;
  logic [WIDTH-1:0] head_data;
  reg_idx_t         head_rd;

  // Ready depends only on registered occupancy, never on out_ready.
  assign in_ready_w  = (count_q < CW'(DEPTH));
  assign out_valid_w = (count_q != '0);
  assign push        = bus.in_valid && in_ready_w && !is_zero_reg(bus.in_rd);
  assign pop         = out_valid_w && bus.out_ready;

  assign wr_entry           = {bus.in_rd, bus.in_data};
  assign {head_rd, head_data} = rd_entry;

  wb_buf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (push && !bus.flush),
    .waddr_i (wptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rptr_q),
    .rdata_o (rd_entry)
  );

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    hold_data_d = hold_data_q;
    hold_rd_d   = hold_rd_q;

    // Remember what the consumer last saw so outputs freeze once empty.
    if (out_valid_w) begin
      hold_data_d = head_data;
      hold_rd_d   = head_rd;
    end

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      hold_data_q <= '0;
      hold_rd_q   <= ZERO_REG;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      hold_data_q <= hold_data_d;
      hold_rd_q   <= hold_rd_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_valid_w ? head_data : hold_data_q;
  assign bus.out_rd    = out_valid_w ? head_rd   : hold_rd_q;
  assign bus.count     = count_q;

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer with WIDTH=32, DEPTH=2.
module tb_alu_wb_buffer;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  alu_wb_buffer_if #(.WIDTH(32), .DEPTH(2)) bus ();

  alu_wb_buffer #(.WIDTH(32), .DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_rd     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    tests++; if (bus.count !== 2'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.count); end
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    tests++; if (bus.out_data !== 32'h0 || bus.out_rd !== 5'd0) begin fails++; $display("FAIL reset_outputs: got %h/%0d want 0/0", bus.out_data, bus.out_rd); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_push();
    bus.in_valid = 1'b1; bus.in_data = 32'hDEADBEEF; bus.in_rd = 5'd3;
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_out_valid: got %b want 1", bus.out_valid); end
    tests++; if (bus.out_data !== 32'hDEADBEEF) begin fails++; $display("FAIL single_out_data: got %h want deadbeef", bus.out_data); end
    tests++; if (bus.out_rd !== 5'd3) begin fails++; $display("FAIL single_out_rd: got %0d want 3", bus.out_rd); end
    tests++; if (bus.count !== 2'd1) begin fails++; $display("FAIL single_count: got %0d want 1", bus.count); end
    tick();
    tests++; if (bus.out_data !== 32'hDEADBEEF || bus.count !== 2'd1) begin fails++; $display("FAIL single_stall_hold: got %h/%0d want deadbeef/1", bus.out_data, bus.count); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    tests++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0) begin fails++; $display("FAIL single_pop: got valid %b count %0d want 0/0", bus.out_valid, bus.count); end
    tests++; if (bus.out_data !== 32'hDEADBEEF || bus.out_rd !== 5'd3) begin fails++; $display("FAIL single_hold_empty: got %h/%0d want deadbeef/3", bus.out_data, bus.out_rd); end
  endtask

  task automatic test_full();
    bus.in_valid = 1'b1; bus.in_data = 32'h1; bus.in_rd = 5'd1;
    tick();
    bus.in_data = 32'h2; bus.in_rd = 5'd2;
    tick();
    tests++; if (bus.count !== 2'd2 || bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_state: got count %0d ready %b want 2/0", bus.count, bus.in_ready); end
    bus.in_data = 32'h3; bus.in_rd = 5'd3;
    tick();
    tests++; if (bus.count !== 2'd2 || bus.out_data !== 32'h1) begin fails++; $display("FAIL full_reject: got count %0d head %h want 2/1", bus.count, bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.count !== 2'd1 || bus.out_data !== 32'h2 || bus.out_rd !== 5'd2) begin fails++; $display("FAIL full_pop_no_push: got count %0d head %h want 1/2", bus.count, bus.out_data); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready_again: got %b want 1", bus.in_ready); end
    tick();
    bus.out_ready = 1'b0;
    tests++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL full_drain: got count %0d valid %b want 0/0", bus.count, bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] head;
    bus.in_valid = 1'b1; bus.in_data = 32'hA; bus.in_rd = 5'd10;
    tick();
    head = 32'hA;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = 32'hB + 32'(i); bus.in_rd = 5'd11 + 5'(i);
      bus.out_ready = 1'b1;
      tests++; if (bus.out_data !== head) begin fails++; $display("FAIL b2b_head_before[%0d]: got %h want %h", i, bus.out_data, head); end
      tick();
      head = 32'hB + 32'(i);
      tests++; if (bus.count !== 2'd1 || bus.out_data !== head || bus.out_rd !== 5'd11 + 5'(i)) begin fails++; $display("FAIL b2b_after[%0d]: got count %0d head %h rd %0d want 1/%h/%0d", i, bus.count, bus.out_data, bus.out_rd, head, 11 + i); end
    end
    bus.in_valid = 1'b0;
    tick();
    bus.out_ready = 1'b0;
    tests++; if (bus.count !== 2'd0) begin fails++; $display("FAIL b2b_drain: got %0d want 0", bus.count); end
  endtask

  task automatic test_rd_zero();
    bus.in_valid = 1'b1; bus.in_data = 32'h55; bus.in_rd = 5'd0;
    tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rd0_ready_before: got %b want 1", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.in_ready !== 1'b1 || bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin fails++; $display("FAIL rd0_dropped: got ready %b count %0d valid %b want 1/0/0", bus.in_ready, bus.count, bus.out_valid); end
    bus.in_valid = 1'b1; bus.in_data = 32'h66; bus.in_rd = 5'd6;
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.count !== 2'd1 || bus.out_data !== 32'h66) begin fails++; $display("FAIL rd0_next_push: got count %0d head %h want 1/66", bus.count, bus.out_data); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    bus.in_valid = 1'b1; bus.in_data = 32'h21; bus.in_rd = 5'd1;
    tick();
    bus.in_data = 32'h22; bus.in_rd = 5'd2;
    tick();
    tests++; if (bus.count !== 2'd2) begin fails++; $display("FAIL flush_pre_count: got %0d want 2", bus.count); end
    bus.flush = 1'b1; bus.out_ready = 1'b1; bus.in_data = 32'h23; bus.in_rd = 5'd3;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tests++; if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_result: got count %0d valid %b ready %b want 0/0/1", bus.count, bus.out_valid, bus.in_ready); end
    bus.in_valid = 1'b1; bus.in_data = 32'h77; bus.in_rd = 5'd7;
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.count !== 2'd1 || bus.out_data !== 32'h77 || bus.out_rd !== 5'd7) begin fails++; $display("FAIL flush_after_push: got count %0d head %h rd %0d want 1/77/7", bus.count, bus.out_data, bus.out_rd); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.in_data = 32'h99; bus.in_rd = 5'd9;
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.count !== 2'd1) begin fails++; $display("FAIL rst_mid_pre: got %0d want 1", bus.count); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_immediate: got valid %b count %0d ready %b want 0/0/1", bus.out_valid, bus.count, bus.in_ready); end
    tests++; if (bus.out_data !== 32'h0 || bus.out_rd !== 5'd0) begin fails++; $display("FAIL rst_mid_outputs: got %h/%0d want 0/0", bus.out_data, bus.out_rd); end
    #1;
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 32'h42; bus.in_rd = 5'd4;
    tick();
    bus.in_valid = 1'b0;
    tests++; if (bus.count !== 2'd1 || bus.out_data !== 32'h42 || bus.out_rd !== 5'd4) begin fails++; $display("FAIL rst_mid_resume: got count %0d head %h rd %0d want 1/42/4", bus.count, bus.out_data, bus.out_rd); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single_push();
    test_full();
    test_back_to_back();
    test_rd_zero();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_wb_buffer.md
ALU_WB_BUFFER -- requirements
Module: alu_wb_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, result data width.
REQ-002 SHALL have parameter DEPTH, default 2, number of buffered entries (power of two, >= 2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the upstream ALU presents a result.
REQ-006 SHALL have port in_ready, output, 1, the buffer can accept a result this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, ALU result word (for a move, a pass-through operand).
REQ-008 SHALL have port in_rd, input, 5, destination register index.
REQ-009 SHALL have port flush, input, 1, synchronous discard of all buffered entries (branch mispredict or exception).
REQ-010 SHALL have port out_valid, output, 1, the head entry is available for writeback.
REQ-011 SHALL have port out_ready, input, 1, the register file accepts the head entry.
REQ-012 SHALL have port out_data, output, WIDTH, head entry data.
REQ-013 SHALL have port out_rd, output, 5, head entry destination index.
REQ-014 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-015 SHALL accept (push) when in_valid && in_ready at a rising edge.
REQ-016 SHALL retire (pop) when out_valid && out_ready at a rising edge.
REQ-017 SHALL drive in_ready = (count < DEPTH) from registered state only, with no combinational path from out_ready.
REQ-018 SHALL drive out_valid = (count != 0), with out_data/out_rd taken from the head entry and stable while out_valid && !out_ready.
REQ-019 SHALL complete a push into an empty buffer with out_valid high the following cycle (latency 1).
REQ-020 SHALL treat an accepted result with in_rd == 0 as consumed but not stored: in_ready behaves as for a normal push, and count, pointers and outputs are unchanged.
REQ-021 SHALL, on a simultaneous push and pop, leave count unchanged and advance both the read and write pointers, preserving order.
REQ-022 SHALL not push when full, even if a pop happens in the same cycle; in_ready is low while full.
REQ-023 SHALL wrap the read and write pointers modulo DEPTH.
REQ-024 SHALL, when flush is high, set count to 0 and reset both pointers at the next edge; flush overrides a push or pop in the same cycle.
REQ-025 SHALL let out_data/out_rd hold their last values when out_valid is low; consumers ignore them.

Reset
REQ-026 SHALL, while rst_n is low, immediately force count=0, pointers=0, out_valid=0, in_ready=1, out_data=0 and out_rd=0.
REQ-027 SHALL abandon any in-flight push or pop when reset asserts mid-operation; no entry survives reset.
REQ-028 SHALL resume operation on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL take WIDTH default, register-index width (5) and the zero-register constant from the shared ISA package.
REQ-030 SHALL implement the storage array as one sub-module, wb_buf_ram (DEPTH x (WIDTH+5) registers, one write port, one asynchronous read port); pointer and count logic stays in alu_wb_buffer.

Verification
REQ-031 SHALL cover: push 0xDEADBEEF, rd=3 into empty buffer with out_ready=0 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_rd=3, count=1.
REQ-032 SHALL cover: push 0x1, 0x2 with out_ready=0 -> count=2, in_ready=0; a third push of 0x3 is not accepted; raise out_ready -> outputs 0x1 then 0x2, then in_ready=1.
REQ-033 SHALL cover: buffer holding 0xA, then simultaneous push 0xB and pop -> count stays 1, head=0xB; repeat 5 times for pointer wrap, in order.
REQ-034 SHALL cover: push 0x55 with rd=0 -> in_ready stays 1, count stays 0, out_valid stays 0.
REQ-035 SHALL cover: count=2, then flush together with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-036 SHALL cover: count=1, then rst_n pulsed low between edges -> out_valid=0 immediately, count=0, and normal push works after release.
